// File: rtl/uart_tx.sv
// UART transmitter: one-entry holding buffer feeding a shift register, one bit per baud tick.
// Start bit appears at the first tick after the character is buffered; in_ready stays low while the buffer is full.
module uart_tx #(
    parameter int DATA_BITS = 8,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tick,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 in_ready,
    output logic                 tx,
    output logic                 busy
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    localparam int                 CNT_W     = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]   LAST_BIT  = CNT_W'(DATA_BITS - 1);
    localparam logic               LAST_STOP = (STOP_BITS == 2);
    localparam logic               HAS_PAR   = (PARITY != 0);
    localparam logic               ODD_PAR   = (PARITY == 1);

    state_t                 state;
    logic [DATA_BITS-1:0]   hold_dat;
    logic [DATA_BITS-1:0]   shift_dat;
    logic                   par_bit;
    logic [CNT_W-1:0]       bit_cnt;
    logic                   stop_cnt;
    logic                   accept;
    logic                   frame_end;
    logic                   load_now;

    // A buffered character moves into the shift register either from IDLE or at the
    // last stop-bit tick; both need the buffer full, so they never coincide with an accept.
    assign accept    = in_valid && in_ready;
    assign frame_end = (state == STOP) && (stop_cnt == LAST_STOP);
    assign load_now  = tick && !in_ready && ((state == IDLE) || frame_end);
    assign busy      = (state != IDLE) || !in_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            tx        <= 1'b1;
            in_ready  <= 1'b1;
            hold_dat  <= '0;
            shift_dat <= '0;
            par_bit   <= 1'b0;
            bit_cnt   <= '0;
            stop_cnt  <= 1'b0;
        end else begin
            if (accept) begin
                hold_dat <= in_data;
                in_ready <= 1'b0;
            end

            if (load_now) begin
                shift_dat <= hold_dat;
                par_bit   <= (^hold_dat) ^ ODD_PAR;
                in_ready  <= 1'b1;
            end

            if (tick) begin
                case (state)
                    IDLE: begin
                        if (!in_ready) begin
                            state <= START;
                            tx    <= 1'b0;
                        end
                    end
                    START: begin
                        state     <= DATA;
                        tx        <= shift_dat[0];
                        shift_dat <= shift_dat >> 1;
                        bit_cnt   <= '0;
                    end
                    DATA: begin
                        if (bit_cnt == LAST_BIT) begin
                            bit_cnt <= '0;
                            if (HAS_PAR) begin
                                state <= PAR;
                                tx    <= par_bit;
                            end else begin
                                state    <= STOP;
                                tx       <= 1'b1;
                                stop_cnt <= 1'b0;
                            end
                        end else begin
                            tx        <= shift_dat[0];
                            shift_dat <= shift_dat >> 1;
                            bit_cnt   <= bit_cnt + CNT_W'(1);
                        end
                    end
                    PAR: begin
                        state    <= STOP;
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                    end
                    STOP: begin
                        if (frame_end) begin
                            stop_cnt <= 1'b0;
                            // Back-to-back frames: go straight to a new start bit.
                            if (!in_ready) begin
                                state <= START;
                                tx    <= 1'b0;
                            end else begin
                                state <= IDLE;
                                tx    <= 1'b1;
                            end
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        tx    <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover no parity, even, odd and two stop bits.
module tb_uart_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       tick = 1'b0;
    logic       tick_en = 1'b1;
    logic [1:0] tcnt = 2'd0;

    logic       iv  [4];
    logic [7:0] id  [4];
    logic       rdy [4];
    logic       txo [4];
    logic       bsy [4];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        tcnt <= tcnt + 2'd1;
        tick <= tick_en && (tcnt == 2'd3);
    end

    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .reset(reset), .tick(tick), .in_valid(iv[0]), .in_data(id[0]),
        .in_ready(rdy[0]), .tx(txo[0]), .busy(bsy[0]));
    uart_tx #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .tick(tick), .in_valid(iv[1]), .in_data(id[1]),
        .in_ready(rdy[1]), .tx(txo[1]), .busy(bsy[1]));
    uart_tx #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut2 (
        .clk(clk), .reset(reset), .tick(tick), .in_valid(iv[2]), .in_data(id[2]),
        .in_ready(rdy[2]), .tx(txo[2]), .busy(bsy[2]));
    uart_tx #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .reset(reset), .tick(tick), .in_valid(iv[3]), .in_data(id[3]),
        .in_ready(rdy[3]), .tx(txo[3]), .busy(bsy[3]));

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Returns #1 after the next rising edge on which tick was high.
    task automatic next_tick();
        logic hit;
        int   n;
        hit = 1'b0;
        n   = 0;
        while (!hit && n < 40) begin
            @(posedge clk);
            hit = tick;
            n++;
        end
        #1;
        check("tick_seen", 32'(hit), 32'd1);
    endtask

    logic [0:14] exp_a [4];
    logic [1:21] exp_b;

    initial begin
        for (int d = 0; d < 4; d++) begin
            iv[d] = 1'b0;
            id[d] = 8'h00;
        end
        exp_a[0] = 15'b101010101011111;
        exp_a[1] = 15'b101110000011111;
        exp_a[2] = 15'b101110000001111;
        exp_a[3] = 15'b101111111111000;
        exp_b    = 21'b0_11000101_1_0_00111100_1_1;

        // Reset state
        #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 4; d++) begin
            check($sformatf("rst_rdy%0d", d), 32'(rdy[d]), 32'd1);
            check($sformatf("rst_tx%0d", d), 32'(txo[d]), 32'd1);
            check($sformatf("rst_busy%0d", d), 32'(bsy[d]), 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // Test A: accept on a tick edge, then one frame per instance.
        begin
            int n;
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (tick !== 1'b1 && n < 40);
        end
        id[0] = 8'h55; id[1] = 8'h07; id[2] = 8'h07; id[3] = 8'hFF;
        for (int d = 0; d < 4; d++) iv[d] = 1'b1;
        for (int s = 0; s < 15; s++) begin
            next_tick();
            if (s == 0) begin
                for (int d = 0; d < 4; d++) begin
                    iv[d] = 1'b0;
                    check($sformatf("a_rdy%0d_s0", d), 32'(rdy[d]), 32'd0);
                end
            end
            for (int d = 0; d < 4; d++)
                check($sformatf("a_tx%0d_s%0d", d, s), 32'(txo[d]), 32'(exp_a[d][s]));
            check($sformatf("a_busy0_s%0d", s), 32'(bsy[0]), (s <= 10) ? 32'd1 : 32'd0);
            check($sformatf("a_busy1_s%0d", s), 32'(bsy[1]), (s <= 11) ? 32'd1 : 32'd0);
            if (s == 1) begin
                check("a_rdy3_s1", 32'(rdy[3]), 32'd1);
                iv[3] = 1'b1;
                id[3] = 8'h00;
                @(posedge clk);
                #1;
                iv[3] = 1'b0;
            end
            if (s == 2) check("a_rdy3_s2", 32'(rdy[3]), 32'd0);
        end

        // Test B: 0xA3 then 0x3C back-to-back with in_valid held high.
        iv[0] = 1'b1;
        id[0] = 8'hA3;
        @(posedge clk);
        #1;
        check("b_rdy_after_a3", 32'(rdy[0]), 32'd0);
        id[0] = 8'h3C;
        for (int t = 1; t <= 21; t++) begin
            next_tick();
            check($sformatf("b_tx_t%0d", t), 32'(txo[0]), 32'(exp_b[t]));
            if (t == 1) begin
                check("b_rdy_t1", 32'(rdy[0]), 32'd1);
                @(posedge clk);
                #1;
                check("b_rdy_after_3c", 32'(rdy[0]), 32'd0);
                id[0] = 8'hFF;
            end
            if (t == 10) iv[0] = 1'b0;
            if (t == 11) check("b_rdy_t11", 32'(rdy[0]), 32'd1);
        end
        check("b_busy_t21", 32'(bsy[0]), 32'd0);

        // Test C: freeze without ticks, then reset during data bit 3 with a char buffered.
        iv[0] = 1'b1;
        id[0] = 8'hF7;
        @(posedge clk);
        #1;
        id[0] = 8'h81;
        next_tick();
        check("c_start", 32'(txo[0]), 32'd0);
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        check("c_buffered", 32'(rdy[0]), 32'd0);
        repeat (4) next_tick();
        check("c_bit3", 32'(txo[0]), 32'd0);
        tick_en = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("c_frozen_tx", 32'(txo[0]), 32'd0);
        check("c_frozen_busy", 32'(bsy[0]), 32'd1);
        reset = 1'b1;
        #1;
        check("c_rst_tx", 32'(txo[0]), 32'd1);
        check("c_rst_rdy", 32'(rdy[0]), 32'd1);
        check("c_rst_busy", 32'(bsy[0]), 32'd0);
        repeat (2) @(posedge clk);
        tick_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        for (int t = 0; t < 12; t++) begin
            next_tick();
            check($sformatf("c_quiet_tx%0d", t), 32'(txo[0]), 32'd1);
            check($sformatf("c_quiet_busy%0d", t), 32'(bsy[0]), 32'd0);
        end

        // First in_valid after reset is accepted on the first edge.
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        iv[0] = 1'b1;
        id[0] = 8'h12;
        @(posedge clk);
        #1;
        iv[0] = 1'b0;
        check("d_rdy", 32'(rdy[0]), 32'd0);
        check("d_busy", 32'(bsy[0]), 32'd1);
        next_tick();
        check("d_start", 32'(txo[0]), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
